// File: rtl/mealy_seq_pkg.sv
// Shared types and width helpers for the parametrised Mealy sequence detector.
package mealy_seq_pkg;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef enum logic [1:0] {SYM_NONE, SYM_VALID, SYM_ILLEGAL} sym_class_t;

  function automatic int sym_w(input int num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  function automatic int idx_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_if.sv
// Button, configuration and match-report signals of the sequence detector.
interface mealy_seq_detector_if
  import mealy_seq_pkg::*;
#(
  parameter int NUM_IN  = 2,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int SYM_W = sym_w(NUM_IN);
  localparam int IDX_W = idx_w(MAX_LEN);
  localparam int LEN_W = len_w(MAX_LEN);

  logic [NUM_IN-1:0] p;
  logic              arm;
  logic              disarm;
  logic              overlap;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [SYM_W-1:0]  cfg_sym;
  logic [LEN_W-1:0]  cfg_len;
  logic              z;
  logic              z_q;
  logic [CNT_W-1:0]  match_cnt;
  logic              running;

  modport master (
    output p, arm, disarm, overlap, cfg_we, cfg_idx, cfg_sym, cfg_len,
    input  z, z_q, match_cnt, running
  );

  modport slave (
    input  p, arm, disarm, overlap, cfg_we, cfg_idx, cfg_sym, cfg_len,
    output z, z_q, match_cnt, running
  );

endinterface

// File: rtl/mealy_seq_detector_encoder.sv
// Combinational one-hot button decoder: symbol index plus none/valid/illegal class.
module onehot_sym_encoder
  import mealy_seq_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int SYM_W  = sym_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] p,
  output logic [SYM_W-1:0]  sym,
  output sym_class_t        cls
);

  always_comb begin
    sym = '0;
    cls = SYM_NONE;
    if (p == '0) begin
      cls = SYM_NONE;
    end else if ((p & (p - NUM_IN'(1))) == '0) begin
      cls = SYM_VALID;
      for (int i = 0; i < NUM_IN; i++) begin
        if (p[i]) sym = SYM_W'(i);
      end
    end else begin
      cls = SYM_ILLEGAL;
    end
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Runtime-programmable Mealy sequence detector with overlap control, arming and
// a saturating match counter; z is asserted in the cycle the final symbol arrives.
module mealy_seq_detector
  import mealy_seq_pkg::*;
#(
  parameter int NUM_IN  = 2,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  mealy_seq_detector_if.slave bus
);

  localparam int SYM_W    = sym_w(NUM_IN);
  localparam int IDX_W    = idx_w(MAX_LEN);
  localparam int LEN_W    = len_w(MAX_LEN);
  localparam int HIST_N   = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;
  localparam int FILL_MAX = MAX_LEN - 1;

  state_t           state;
  logic [SYM_W-1:0] pattern [MAX_LEN];
  logic [SYM_W-1:0] hist [HIST_N];
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] fill;
  logic [SYM_W-1:0] sym;
  sym_class_t       sym_cls;
  logic             seq_ok;
  logic             fill_ok;
  logic             z;
  logic             z_reg;
  logic [CNT_W-1:0] cnt;

  onehot_sym_encoder #(.NUM_IN(NUM_IN), .SYM_W(SYM_W)) u_enc (
    .p   (bus.p),
    .sym (sym),
    .cls (sym_cls)
  );

  assign len_clamped = (int'(bus.cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : bus.cfg_len;
  assign fill_ok     = int'(fill) >= int'(len) - 1;

  // hist[0] is the newest symbol, so hist[k] lines up with pattern[len-2-k].
  always_comb begin
    seq_ok = (pattern[IDX_W'(int'(len) - 1)] == sym);
    for (int k = 0; k < HIST_N; k++) begin
      if ((k < int'(len) - 1) && (pattern[IDX_W'(int'(len) - 2 - k)] != hist[k])) begin
        seq_ok = 1'b0;
      end
    end
  end

  assign z = (state == S_RUN) && (sym_cls == SYM_VALID) && (len != '0) && fill_ok && seq_ok;

  assign bus.z         = z;
  assign bus.z_q       = z_reg;
  assign bus.match_cnt = cnt;
  assign bus.running   = (state == S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      len   <= '0;
      fill  <= '0;
      z_reg <= 1'b0;
      cnt   <= '0;
      for (int i = 0; i < MAX_LEN; i++) pattern[i] <= '0;
    end else begin
      z_reg <= z;
      if (z && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (bus.cfg_we && (int'(bus.cfg_idx) < MAX_LEN)) pattern[bus.cfg_idx] <= bus.cfg_sym;
          if (bus.arm && !bus.disarm) begin
            state <= S_RUN;
            len   <= len_clamped;
            fill  <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (bus.disarm) begin
            state <= S_IDLE;
            fill  <= '0;
          end else if (sym_cls == SYM_VALID) begin
            if (z && !bus.overlap) fill <= '0;
            else if (int'(fill) < FILL_MAX) fill <= fill + LEN_W'(1);
          end else if (sym_cls == SYM_ILLEGAL) begin
            fill <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Symbol history carries no reset; fill decides how much of it is trusted.
  always_ff @(posedge clk) begin
    if ((state == S_RUN) && (sym_cls == SYM_VALID)) begin
      hist[0] <= sym;
      for (int k = 1; k < HIST_N; k++) hist[k] <= hist[k-1];
    end
  end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: directed scenarios plus random traffic against a queue-based model.
module tb_mealy_seq_detector;
  import mealy_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mealy_seq_detector_if #(.NUM_IN(2), .MAX_LEN(8), .CNT_W(8)) bus ();
  mealy_seq_detector_if #(.NUM_IN(2), .MAX_LEN(8), .CNT_W(2)) bus2 ();

  assign bus2.p       = bus.p;
  assign bus2.arm     = bus.arm;
  assign bus2.disarm  = bus.disarm;
  assign bus2.overlap = bus.overlap;
  assign bus2.cfg_we  = bus.cfg_we;
  assign bus2.cfg_idx = bus.cfg_idx;
  assign bus2.cfg_sym = bus.cfg_sym;
  assign bus2.cfg_len = bus.cfg_len;

  mealy_seq_detector #(.NUM_IN(2), .MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  mealy_seq_detector #(.NUM_IN(2), .MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;

  int m_pat [8];
  int m_len;
  int m_fill;
  int m_cnt;
  bit m_run;
  bit m_zq;
  int hq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int cur_sym();
    int s = 0;
    for (int i = 0; i < 2; i++) if (bus.p[i]) s = i;
    return s;
  endfunction

  function automatic bit model_z();
    if (!reset_n || !m_run || $countones(bus.p) != 1 || m_len == 0) return 1'b0;
    if (m_fill < m_len - 1) return 1'b0;
    if (m_pat[m_len-1] != cur_sym()) return 1'b0;
    for (int j = 0; j < m_len - 1; j++)
      if (hq[hq.size() - (m_len - 1) + j] != m_pat[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_fill = 0; m_len = 0; m_cnt = 0; m_zq = 0;
    for (int i = 0; i < 8; i++) m_pat[i] = 0;
  endfunction

  // Compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit ez;
    int c;
    @(negedge clk);
    ez = model_z();
    chk("z", bus.z, ez);
    chk("z_cnt2dut", bus2.z, ez);
    chk("z_q", bus.z_q, m_zq);
    chk("match_cnt", bus.match_cnt, sat(m_cnt, 255));
    chk("match_cnt_w2", bus2.match_cnt, sat(m_cnt, 3));
    chk("running", bus.running, m_run);
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_zq = ez;
      if (ez) m_cnt++;
      if (!m_run) begin
        if (bus.cfg_we) m_pat[bus.cfg_idx] = bus.cfg_sym;
        if (bus.arm && !bus.disarm) begin
          m_run = 1; m_fill = 0; m_cnt = 0;
          m_len = (bus.cfg_len > 8) ? 8 : int'(bus.cfg_len);
        end
      end else if (bus.disarm) begin
        m_run = 0; m_fill = 0;
      end else begin
        c = $countones(bus.p);
        if (c == 1) begin
          hq.push_back(cur_sym());
          if (hq.size() > 32) void'(hq.pop_front());
          m_fill = (ez && !bus.overlap) ? 0 : sat(m_fill + 1, 7);
        end else if (c > 1) begin
          m_fill = 0;
        end
      end
    end
    #1;
    bus.arm = 0; bus.disarm = 0; bus.cfg_we = 0;
  endtask

  task automatic wr(input int idx, input int s);
    bus.p = 2'b00; bus.cfg_we = 1; bus.cfg_idx = 3'(idx); bus.cfg_sym = 1'(s);
    tick();
  endtask

  task automatic arm_with(input int l, input bit ov);
    bus.p = 2'b00; bus.cfg_len = 4'(l); bus.overlap = ov; bus.arm = 1;
    tick();
  endtask

  task automatic disarm_now();
    bus.p = 2'b00; bus.disarm = 1;
    tick();
  endtask

  task automatic feed(input logic [1:0] pv, input bit ez, input string name);
    bus.p = pv;
    #1;
    chk(name, bus.z, ez);
    tick();
  endtask

  initial begin
    bus.p = 0; bus.arm = 0; bus.disarm = 0; bus.overlap = 1;
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_sym = 0; bus.cfg_len = 0;
    model_reset();
    #1;
    chk("rst_z", bus.z, 0);
    chk("rst_z_q", bus.z_q, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_running", bus.running, 0);
    repeat (2) tick();
    reset_n = 1;
    tick();

    // Basic [0,0,1]
    wr(0, 0); wr(1, 0); wr(2, 1);
    arm_with(3, 1);
    chk("running_after_arm", bus.running, 1);
    feed(2'b01, 0, "basic_c1");
    feed(2'b01, 0, "basic_c2");
    feed(2'b10, 1, "basic_c3");
    chk("basic_zq", bus.z_q, 1);
    chk("basic_cnt", bus.match_cnt, 1);

    // Gaps, then an illegal symbol breaking the run
    feed(2'b01, 0, "gap_c1"); feed(2'b00, 0, "gap_c2"); feed(2'b01, 0, "gap_c3");
    feed(2'b00, 0, "gap_c4"); feed(2'b10, 1, "gap_match");
    feed(2'b01, 0, "ill_c1"); feed(2'b11, 0, "ill_c2");
    feed(2'b01, 0, "ill_c3"); feed(2'b10, 0, "ill_c4");
    chk("ill_cnt", bus.match_cnt, 2);

    // Pattern write while running must be ignored
    wr(2, 0);
    feed(2'b01, 0, "cfgrun_c1"); feed(2'b01, 0, "cfgrun_c2"); feed(2'b10, 1, "cfgrun_match");
    disarm_now();
    chk("disarm_running", bus.running, 0);

    // Overlap on and off, pattern [0,0]
    wr(0, 0); wr(1, 0);
    arm_with(2, 1);
    feed(2'b01, 0, "ov1_c1"); feed(2'b01, 1, "ov1_c2");
    feed(2'b01, 1, "ov1_c3"); feed(2'b01, 1, "ov1_c4");
    chk("ov1_cnt", bus.match_cnt, 3);
    disarm_now();
    arm_with(2, 0);
    chk("arm_clears_cnt", bus.match_cnt, 0);
    feed(2'b01, 0, "ov0_c1"); feed(2'b01, 1, "ov0_c2");
    feed(2'b01, 0, "ov0_c3"); feed(2'b01, 1, "ov0_c4");
    chk("ov0_cnt", bus.match_cnt, 2);

    // Simultaneous arm and disarm while running
    bus.p = 2'b00; bus.arm = 1; bus.disarm = 1;
    tick();
    chk("armdis_running", bus.running, 0);

    // Length zero disables detection
    arm_with(0, 1);
    for (int i = 0; i < 4; i++) feed(2'b01, 0, "len0");
    disarm_now();

    // Length 15 clamps to 8
    begin
      int cp [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
      for (int i = 0; i < 8; i++) wr(i, cp[i]);
      arm_with(15, 1);
      for (int i = 0; i < 8; i++) feed(cp[i] ? 2'b10 : 2'b01, (i == 7), "clamp");
      disarm_now();
    end

    // Saturation of the 2-bit counter
    wr(0, 1);
    arm_with(1, 1);
    for (int i = 0; i < 5; i++) feed(2'b10, 1, "sat_z");
    chk("sat_cnt8", bus.match_cnt, 5);
    chk("sat_cnt2", bus2.match_cnt, 3);
    feed(2'b10, 1, "sat_z6");
    chk("sat_cnt2_hold", bus2.match_cnt, 3);
    disarm_now();

    // Asynchronous reset mid-sequence
    wr(0, 0); wr(1, 0); wr(2, 1);
    arm_with(3, 1);
    feed(2'b01, 0, "mid_c1"); feed(2'b01, 0, "mid_c2"); feed(2'b10, 1, "mid_c3");
    feed(2'b01, 0, "mid_c4"); feed(2'b01, 0, "mid_c5");
    bus.p = 2'b10;
    #1;
    chk("pre_rst_z", bus.z, 1);
    @(negedge clk);
    #2;
    reset_n = 0;
    model_reset();
    #1;
    chk("mid_rst_z", bus.z, 0);
    chk("mid_rst_cnt", bus.match_cnt, 0);
    chk("mid_rst_running", bus.running, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    bus.p = 2'b10;
    #1;
    chk("post_rst_z", bus.z, 0);
    tick();
    chk("post_rst_running", bus.running, 0);

    // Random traffic
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wr(i, $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) arm_with($urandom_range(9, 15), $urandom_range(0, 1));
      else arm_with($urandom_range(0, n), $urandom_range(0, 1));
      for (int c = 0; c < 150; c++) begin
        int v = $urandom_range(0, 15);
        if (v == 0) bus.p = 2'b00;
        else if (v == 1) bus.p = 2'b11;
        else bus.p = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        if ($urandom_range(0, 40) == 0) begin
          bus.cfg_we = 1; bus.cfg_idx = 3'($urandom_range(0, 7)); bus.cfg_sym = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 80) == 0) bus.disarm = 1;
        else if (!m_run && $urandom_range(0, 3) == 0) bus.arm = 1;
        tick();
      end
      disarm_now();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
